// File: rtl/rgb_pwm_pkg.sv
// Shared definitions for the RGB PWM fader: sequencer states, channel
// vector type and the one-LSB fade step helper.
package rgb_pwm_pkg;

    localparam int NUM_CH = 3;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        FADE   = 2'd3
    } state_t;

    // One bit per colour channel (index 0 = RGB0).
    typedef logic [NUM_CH-1:0] ch_bits_t;

    // Move cur one LSB toward tgt; hold when already equal.
    function automatic int step_toward(input int cur, input int tgt);
        int nxt;
        if (tgt > cur) begin
            nxt = cur + 32'sd1;
        end else if (tgt < cur) begin
            nxt = cur - 32'sd1;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rgb_pwm_fader_if.sv
// Colour command channel: valid/ready handshake carrying the fade flag and
// the three target duties.
interface rgb_pwm_fader_if #(
    parameter int PWM_BITS = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_fade;
    logic [PWM_BITS-1:0] cmd_r;
    logic [PWM_BITS-1:0] cmd_g;
    logic [PWM_BITS-1:0] cmd_b;

    modport master (
        output cmd_valid, cmd_fade, cmd_r, cmd_g, cmd_b,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_fade, cmd_r, cmd_g, cmd_b,
        output cmd_ready
    );
endinterface

// File: rtl/rgb_pwm_timebase.sv
// PWM timebase: prescaler producing tick, period counter pcnt and the
// period-end strobe pend. Held at zero while run is low.
module rgb_pwm_timebase #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    output logic                tick,
    output logic [PWM_BITS-1:0] pcnt,
    output logic                pend
);
    localparam int                PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
    localparam logic [PWM_BITS-1:0] PCNT_LAST = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PCNT_ONE  = PWM_BITS'(1);

    logic [PRE_W-1:0] pre_r;

    assign tick = run & (pre_r == PRE_LAST);
    assign pend = tick & (pcnt == PCNT_LAST);

    // Prescaler and PWM counter; both cleared whenever the sequencer is off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r <= {PRE_W{1'b0}};
            pcnt  <= {PWM_BITS{1'b0}};
        end else if (!run) begin
            pre_r <= {PRE_W{1'b0}};
            pcnt  <= {PWM_BITS{1'b0}};
        end else if (tick) begin
            pre_r <= {PRE_W{1'b0}};
            pcnt  <= pcnt + PCNT_ONE;
        end else begin
            pre_r <= pre_r + PRE_ONE;
            pcnt  <= pcnt;
        end
    end

endmodule

// File: rtl/rgb_pwm_fader.sv
// Three-channel PWM / fade sequencer for an SB_RGBA_DRV: current-reference
// warm-up, then jump or ramp commands applied only at PWM period boundaries.
module rgb_pwm_fader
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 16,
    parameter int FADE_DIV      = 4,
    parameter int WARMUP_CYCLES = 1200
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           en,
    rgb_pwm_fader_if.slave cmd,
    output logic           rgb0_pwm,
    output logic           rgb1_pwm,
    output logic           rgb2_pwm,
    output logic           curren,
    output logic           rgbleden,
    output logic           busy
);
    localparam int                WARM_W    = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int                FADE_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);
    localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_DIV - 1);
    localparam logic [FADE_W-1:0] FADE_ONE  = FADE_W'(1);

    state_t              state_r;
    state_t              state_next_s;
    logic [WARM_W-1:0]   wcnt_r;
    logic [FADE_W-1:0]   fcnt_r;
    logic                jmp_pend_r;

    logic [PWM_BITS-1:0] duty_r      [NUM_CH];
    logic [PWM_BITS-1:0] tgt_r       [NUM_CH];
    logic [PWM_BITS-1:0] cmd_duty_s  [NUM_CH];
    logic [PWM_BITS-1:0] step_duty_s [NUM_CH];
    ch_bits_t            at_tgt_s;
    ch_bits_t            pwm_cmp_s;
    ch_bits_t            pwm_r;

    logic                tick_s;
    logic                pend_s;
    logic [PWM_BITS-1:0] pcnt_s;
    logic                period_end_s;
    logic                accept_s;
    logic                fade_step_s;
    logic                run_s;
    logic                run_next_s;
    logic                clear_s;

    logic                ready_r;
    logic                curren_r;
    logic                rgbleden_r;
    logic                busy_r;

    rgb_pwm_timebase #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk   (clk),
        .rst_n (resetn),
        .run   (run_s),
        .tick  (tick_s),
        .pcnt  (pcnt_s),
        .pend  (pend_s)
    );

    assign run_s        = (state_r != OFF);
    assign run_next_s   = (state_next_s != OFF);
    assign clear_s      = (state_next_s == OFF);
    // pend is only defined on a tick; qualify it so a period end is unambiguous.
    assign period_end_s = tick_s & pend_s;
    assign accept_s     = cmd.cmd_valid & ready_r;
    assign fade_step_s  = (state_r == FADE) & period_end_s & (fcnt_r == FADE_LAST);

    assign cmd_duty_s[0] = cmd.cmd_r;
    assign cmd_duty_s[1] = cmd.cmd_g;
    assign cmd_duty_s[2] = cmd.cmd_b;

    // Per-channel compare and one-LSB step toward target.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign step_duty_s[i] = PWM_BITS'(step_toward(int'(duty_r[i]), int'(tgt_r[i])));
        assign at_tgt_s[i]    = (step_duty_s[i] == tgt_r[i]);
        assign pwm_cmp_s[i]   = (pcnt_s < duty_r[i]);
    end

    // Next-state logic; dropping en forces OFF from any state.
    always_comb begin
        state_next_s = state_r;
        if (!en) begin
            state_next_s = OFF;
        end else begin
            case (state_r)
                OFF: begin
                    state_next_s = WARMUP;
                end
                WARMUP: begin
                    if (wcnt_r == WARM_LAST) begin
                        state_next_s = RUN;
                    end else begin
                        state_next_s = WARMUP;
                    end
                end
                RUN: begin
                    if (accept_s && cmd.cmd_fade) begin
                        state_next_s = FADE;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                FADE: begin
                    if (fade_step_s && (&at_tgt_s)) begin
                        state_next_s = RUN;
                    end else begin
                        state_next_s = FADE;
                    end
                end
                default: begin
                    state_next_s = OFF;
                end
            endcase
        end
    end

    // State register, warm-up counter, fade-period counter and jump-pending flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= OFF;
            wcnt_r     <= {WARM_W{1'b0}};
            fcnt_r     <= {FADE_W{1'b0}};
            jmp_pend_r <= 1'b0;
        end else begin
            state_r <= state_next_s;

            if ((state_r == WARMUP) && (state_next_s == WARMUP)) begin
                wcnt_r <= wcnt_r + WARM_ONE;
            end else begin
                wcnt_r <= {WARM_W{1'b0}};
            end

            if ((state_r != FADE) || (state_next_s != FADE)) begin
                fcnt_r <= {FADE_W{1'b0}};
            end else if (period_end_s) begin
                fcnt_r <= (fcnt_r == FADE_LAST) ? {FADE_W{1'b0}} : (fcnt_r + FADE_ONE);
            end else begin
                fcnt_r <= fcnt_r;
            end

            // A newer jump overrides an unapplied one; a fade cancels it.
            if (clear_s) begin
                jmp_pend_r <= 1'b0;
            end else if (accept_s) begin
                jmp_pend_r <= ~cmd.cmd_fade;
            end else if (period_end_s) begin
                jmp_pend_r <= 1'b0;
            end else begin
                jmp_pend_r <= jmp_pend_r;
            end
        end
    end

    // Target and active duty registers; duty only changes on a period end.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty_r[i] <= {PWM_BITS{1'b0}};
                tgt_r[i]  <= {PWM_BITS{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clear_s) begin
                    duty_r[i] <= {PWM_BITS{1'b0}};
                    tgt_r[i]  <= {PWM_BITS{1'b0}};
                end else begin
                    if (accept_s) begin
                        tgt_r[i] <= cmd_duty_s[i];
                    end else begin
                        tgt_r[i] <= tgt_r[i];
                    end

                    if (period_end_s && jmp_pend_r) begin
                        duty_r[i] <= tgt_r[i];
                    end else if (fade_step_s) begin
                        duty_r[i] <= step_duty_s[i];
                    end else begin
                        duty_r[i] <= duty_r[i];
                    end
                end
            end
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_r      <= {NUM_CH{1'b0}};
            curren_r   <= 1'b0;
            rgbleden_r <= 1'b0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            pwm_r      <= run_next_s ? pwm_cmp_s : {NUM_CH{1'b0}};
            curren_r   <= run_next_s;
            rgbleden_r <= (state_next_s == RUN) || (state_next_s == FADE);
            ready_r    <= (state_next_s == RUN);
            busy_r     <= (state_next_s == WARMUP) || (state_next_s == FADE);
        end
    end

    assign rgb0_pwm      = pwm_r[0];
    assign rgb1_pwm      = pwm_r[1];
    assign rgb2_pwm      = pwm_r[2];
    assign curren        = curren_r;
    assign rgbleden      = rgbleden_r;
    assign busy          = busy_r;
    assign cmd.cmd_ready = ready_r;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Self-checking bench for rgb_pwm_fader: directed scenarios plus randomized
// jump/fade commands, compared every clock against a time-based reference.
module tb_rgb_pwm_fader;

    localparam int PWM_BITS      = 8;
    localparam int PRESCALE      = 1;
    localparam int FADE_DIV      = 1;
    localparam int WARMUP_CYCLES = 10;
    localparam int PERIOD        = 1 << PWM_BITS;

    localparam int M_OFF  = 0;
    localparam int M_WARM = 1;
    localparam int M_RUN  = 2;
    localparam int M_FADE = 3;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    logic en     = 1'b0;
    logic rgb0_pwm, rgb1_pwm, rgb2_pwm, curren, rgbleden, busy;

    rgb_pwm_fader_if #(.PWM_BITS(PWM_BITS)) cmd_bus ();

    rgb_pwm_fader #(
        .PWM_BITS      (PWM_BITS),
        .PRESCALE      (PRESCALE),
        .FADE_DIV      (FADE_DIV),
        .WARMUP_CYCLES (WARMUP_CYCLES)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .en       (en),
        .cmd      (cmd_bus),
        .rgb0_pwm (rgb0_pwm),
        .rgb1_pwm (rgb1_pwm),
        .rgb2_pwm (rgb2_pwm),
        .curren   (curren),
        .rgbleden (rgbleden),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: on_cnt = clocks since the block left OFF; the PWM
    // position is derived from it arithmetically.
    int       m_on;
    int       m_mode;
    int       m_duty [3];
    int       m_tgt  [3];
    bit       m_jpend;
    int       m_fpend;
    bit       m_acc;
    bit [6:0] m_out;   // {pwm2, pwm1, pwm0, curren, rgbleden, cmd_ready, busy}

    task automatic check_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on    = 0;
        m_mode  = M_OFF;
        m_jpend = 1'b0;
        m_fpend = 0;
        m_out   = 7'd0;
        for (int c = 0; c < 3; c++) begin
            m_duty[c] = 0;
            m_tgt[c]  = 0;
        end
    endtask

    function automatic int clampd(input int v);
        int r;
        r = v;
        if (r < 0) r = 0;
        if (r > PERIOD - 1) r = PERIOD - 1;
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs present before it.
    task automatic model_edge();
        int       cyc_idx, pos;
        bit       pend, accept, done;
        bit [2:0] pwm;
        int       cmdv [3];
        m_acc = 1'b0;
        if (!resetn || !en) begin
            model_reset();
            return;
        end
        cmdv[0] = int'(cmd_bus.cmd_r);
        cmdv[1] = int'(cmd_bus.cmd_g);
        cmdv[2] = int'(cmd_bus.cmd_b);
        if (m_on >= 1) begin
            cyc_idx = m_on - 1;
            pos     = (cyc_idx / PRESCALE) % PERIOD;
            pend    = ((cyc_idx % PRESCALE) == PRESCALE - 1) && (pos == PERIOD - 1);
        end else begin
            pos  = 0;
            pend = 1'b0;
        end
        for (int c = 0; c < 3; c++) pwm[c] = (pos < m_duty[c]);
        accept = cmd_bus.cmd_valid && (m_mode == M_RUN);
        case (m_mode)
            M_OFF:  m_mode = M_WARM;
            M_WARM: if (m_on == WARMUP_CYCLES) m_mode = M_RUN;
            M_RUN: begin
                if (pend && m_jpend) m_duty = m_tgt;
                if (pend) m_jpend = 1'b0;
                if (accept) begin
                    m_acc = 1'b1;
                    m_tgt = cmdv;
                    if (cmd_bus.cmd_fade) begin
                        m_mode  = M_FADE;
                        m_fpend = 0;
                        m_jpend = 1'b0;
                    end else begin
                        m_jpend = 1'b1;
                    end
                end
            end
            M_FADE: begin
                if (pend) begin
                    m_fpend++;
                    if (m_fpend == FADE_DIV) begin
                        m_fpend = 0;
                        done    = 1'b1;
                        for (int c = 0; c < 3; c++) begin
                            if (m_duty[c] < m_tgt[c]) m_duty[c]++;
                            else if (m_duty[c] > m_tgt[c]) m_duty[c]--;
                            if (m_duty[c] != m_tgt[c]) done = 1'b0;
                        end
                        if (done) m_mode = M_RUN;
                    end
                end
            end
            default: m_mode = M_OFF;
        endcase
        m_on++;
        m_out = {pwm, 1'b1, (m_mode == M_RUN) || (m_mode == M_FADE),
                 m_mode == M_RUN, (m_mode == M_WARM) || (m_mode == M_FADE)};
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("outs", int'({rgb2_pwm, rgb1_pwm, rgb0_pwm, curren, rgbleden,
                               cmd_bus.cmd_ready, busy}), int'(m_out));
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send(input bit fade, input int r, input int g, input int b);
        int waited;
        waited            = 0;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_fade  = fade;
        cmd_bus.cmd_r     = PWM_BITS'(r);
        cmd_bus.cmd_g     = PWM_BITS'(g);
        cmd_bus.cmd_b     = PWM_BITS'(b);
        do begin
            cyc();
            waited++;
        end while (!m_acc && waited < 5000);
        check_eq("cmd_accepted", int'(m_acc), 1);
        cmd_bus.cmd_valid = 1'b0;
    endtask

    task automatic count_high(output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < PERIOD; i++) begin
            cyc();
            c0 += int'(rgb0_pwm);
            c1 += int'(rgb1_pwm);
            c2 += int'(rgb2_pwm);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, h1, h2, waited;
        bit fd;
        int r, g, b;

        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_fade  = 1'b0;
        cmd_bus.cmd_r     = '0;
        cmd_bus.cmd_g     = '0;
        cmd_bus.cmd_b     = '0;
        model_reset();

        // Reset values
        #1 resetn = 1'b0;
        #2;
        check_eq("rst_outs", int'({rgb2_pwm, rgb1_pwm, rgb0_pwm, curren, rgbleden,
                                   cmd_bus.cmd_ready, busy}), 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        en     = 1'b1;

        // Warm-up sequencing
        cyc();
        check_eq("curren_at_1", int'(curren), 1);
        check_eq("leden_at_1", int'(rgbleden), 0);
        run_cycles(9);
        check_eq("leden_at_10", int'(rgbleden), 0);
        cyc();
        check_eq("leden_at_11", int'(rgbleden), 1);
        check_eq("ready_at_11", int'(cmd_bus.cmd_ready), 1);

        // Jump to 64/128/255
        send(1'b0, 64, 128, 255);
        run_cycles(300);
        count_high(h0, h1, h2);
        check_eq("jump_r_high", h0, 64);
        check_eq("jump_g_high", h1, 128);
        check_eq("jump_b_high", h2, 255);

        // Back-to-back jumps: only the newest applies
        send(1'b0, 10, 10, 10);
        send(1'b0, 20, 20, 20);
        run_cycles(300);
        count_high(h0, h1, h2);
        check_eq("b2b_r_high", h0, 20);

        // Fade 0 -> (3,0,1)
        send(1'b0, 0, 0, 0);
        run_cycles(300);
        send(1'b1, 3, 0, 1);
        check_eq("fade_busy", int'(busy), 1);
        waited = 0;
        while (!cmd_bus.cmd_ready && waited < 2000) begin
            cyc();
            waited++;
        end
        check_eq("fade_ready_back", int'(cmd_bus.cmd_ready), 1);
        count_high(h0, h1, h2);
        check_eq("fade_r_high", h0, 3);
        check_eq("fade_g_high", h1, 0);
        check_eq("fade_b_high", h2, 1);

        // Randomized jumps and short fades
        for (int k = 0; k < 12; k++) begin
            fd = 1'($urandom_range(0, 1));
            if (fd) begin
                run_cycles(PERIOD + 2 + int'($urandom_range(0, 60)));
                r = clampd(m_tgt[0] + int'($urandom_range(0, 10)) - 5);
                g = clampd(m_tgt[1] + int'($urandom_range(0, 10)) - 5);
                b = clampd(m_tgt[2] + int'($urandom_range(0, 10)) - 5);
            end else begin
                run_cycles(int'($urandom_range(0, 40)));
                r = int'($urandom_range(0, PERIOD - 1));
                g = int'($urandom_range(0, PERIOD - 1));
                b = int'($urandom_range(0, PERIOD - 1));
            end
            send(fd, r, g, b);
        end
        run_cycles(3 * PERIOD);

        // Drop en mid-fade, then full warm-up again
        r = (m_tgt[0] >= 128) ? m_tgt[0] - 5 : m_tgt[0] + 5;
        send(1'b1, r, m_tgt[1], m_tgt[2]);
        run_cycles(300);
        check_eq("midfade_busy", int'(busy), 1);
        en = 1'b0;
        cyc();
        check_eq("off_outs", int'({rgb2_pwm, rgb1_pwm, rgb0_pwm, curren, rgbleden,
                                   cmd_bus.cmd_ready, busy}), 0);
        run_cycles(3);
        en = 1'b1;
        cyc();
        check_eq("rewarm_curren", int'(curren), 1);
        run_cycles(9);
        check_eq("rewarm_leden_10", int'(rgbleden), 0);
        cyc();
        check_eq("rewarm_leden_11", int'(rgbleden), 1);

        // Asynchronous reset while rgb0 is high
        send(1'b0, 200, 0, 0);
        run_cycles(300);
        waited = 0;
        while (!m_out[4] && waited < 2 * PERIOD) begin
            cyc();
            waited++;
        end
        check_eq("rgb0_before_rst", int'(rgb0_pwm), 1);
        #2 resetn = 1'b0;
        #1;
        check_eq("rgb0_async_rst", int'(rgb0_pwm), 0);
        run_cycles(2);
        resetn = 1'b1;
        run_cycles(WARMUP_CYCLES + 2);
        count_high(h0, h1, h2);
        check_eq("post_rst_r_high", h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
